tpcd_pattern_gen: RTL and testbench
===================================

Name: tpcd_pattern_gen

Overview:
Stimulus transmitter and response collector for the dartboard scoring core.
- Drives the core's input protocol: a 16-cycle score burst on in_valid_1, an idle gap, then a dart burst on in_valid_2.
- Then waits for out_valid and captures out_sum.
- Sits between the self-test controller (start/seed/result) and the scoring core, so the core can be exercised on-chip without a testbench.

Parameters:
GAP_CYCLES, 2, idle cycles between last score and first dart (>=1)
TIMEOUT, 100, max cycles in WAIT_RESP before declaring timeout
LFSR_TAPS, 16'hB400, Galois LFSR feedback mask

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to run one pattern; honoured only in IDLE
seed  in  16  LFSR seed, sampled with start
num_darts  in  4  dart count, sampled with start; 0 means 16
in_valid_1  out  1  score burst valid (to core)
in_score  out  3  board score (to core)
in_valid_2  out  1  dart burst valid (to core)
in_dart  out  4  dart target (to core)
in_rotation  out  3  rotation step (to core)
rotate_flag  out  1  rotation direction, 1=ccw (to core)
out_valid  in  1  core result valid
out_sum  in  7  core result
busy  out  1  high from cycle after accepted start until done pulse
done  out  1  one-cycle completion pulse
timeout  out  1  valid with done; 1 = no response
result_sum  out  7  captured out_sum; held until next start

Behaviour:
- Reset: all outputs 0, lfsr=16'hACE1, state IDLE. Reset mid-run aborts immediately; all core-side outputs go 0 asynchronously.
- All outputs registered. Data outputs are forced to 0 whenever their valid is low.
- LFSR step: next = (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0). Advances exactly once per driven valid cycle, after its value is used.
- Seed 16'h0000 is replaced by 16'hACE1.
- Field mapping per driven cycle:
  - Score: in_score = lfsr[2:0].
  - Dart: in_dart = lfsr[3:0], in_rotation = lfsr[6:4], rotate_flag = lfsr[7].
- States:
  - IDLE: on start, latch seed into lfsr, latch dart count (0 maps to 16), go SCORE. busy=1 from next edge. start in any other state is ignored.
  - SCORE: in_valid_1=1 for exactly 16 consecutive cycles; 4-bit counter; after 16th go GAP.
  - GAP: all valids 0 for GAP_CYCLES cycles, then DART.
  - DART: in_valid_2=1 for exactly dart-count consecutive cycles, then WAIT_RESP. Timeout counter is cleared on entry.
  - WAIT_RESP, normal completion: first cycle with out_valid=1 → result_sum<=out_sum, timeout<=0, done<=1, then IDLE.
  - WAIT_RESP, timeout: counter increments each cycle. On reaching TIMEOUT with no out_valid → result_sum<=0, timeout<=1, done<=1, then IDLE.
  - WAIT_RESP, same-cycle tie: out_valid on the cycle the counter hits TIMEOUT counts as a response (no timeout).
- out_valid outside WAIT_RESP is ignored and captures nothing.
- done is a single-cycle pulse; busy falls on the same edge done rises.
- timeout and result_sum hold until the next accepted start, then clear to 0.
- Latency:
  - start sampled at edge N → first in_valid_1 at edge N+1.
  - First in_valid_2 at edge N+17+GAP_CYCLES.
- Width: a max of 16 darts × 7 points = 112 fits in 7 bits; the block does no arithmetic on the sum.

Decomposition:
- Shared package tpcd_pkg holds:
  - state enum (IDLE, SCORE, GAP, DART, WAIT_RESP);
  - constant NUM_SCORES=16;
  - constant DEFAULT_SEED=16'hACE1;
  - field widths for score (3), dart (4), rotation (3).
- One natural sub-module: tpcd_lfsr16 (load, step, seed-zero substitution, taps parameter).

Test Plan:
- Reset: assert rst_n=0 mid-DART → all outputs 0 immediately; after release, state is IDLE and busy=0.
- Score burst: seed=16'h0001, start → in_valid_1 high exactly 16 cycles. First in_score=1 (lfsr 0001); second in_score=0 (lfsr B400).
- Dart burst: num_darts=3, GAP_CYCLES=2 → exactly 2 idle cycles after the burst, then in_valid_2 high exactly 3 cycles. Fields match the LFSR continuation; num_darts=0 → 16 dart cycles.
- Response: model core returns out_valid with out_sum=7'd45 → 5 cycles after last dart: result_sum=45, timeout=0, done pulse 1 cycle, busy falls.
- Timeout: no out_valid → done with timeout=1 and result_sum=0 after exactly TIMEOUT cycles in WAIT_RESP. Also check out_valid coincident with TIMEOUT → timeout=0.
- Ignored inputs: start asserted during SCORE causes no restart; stray out_valid in IDLE leaves result_sum unchanged; seed=0 produces the same stream as seed=16'hACE1.

Source files
------------

// File: rtl/tpcd_pkg.sv
// tpcd_pkg: shared states, constants and field widths for the dartboard pattern generator
package tpcd_pkg;
    typedef enum logic [2:0] {IDLE, SCORE, GAP, DART, WAIT_RESP} state_t;
    localparam int NUM_SCORES = 16;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam int SCORE_W = 3;
    localparam int DART_W = 4;
    localparam int ROT_W = 3;
    localparam int SUM_W = 7;
    function automatic logic [4:0] dart_count(input logic [3:0] n);
        return n == 4'd0 ? 5'd16 : {1'b0, n};
    endfunction
endpackage

// File: rtl/tpcd_pattern_gen_if.sv
// tpcd_pattern_gen_if: stimulus/response bus between the pattern generator and the scoring core
interface tpcd_pattern_gen_if;
    import tpcd_pkg::*;
    logic               in_valid_1;
    logic [SCORE_W-1:0] in_score;
    logic               in_valid_2;
    logic [DART_W-1:0]  in_dart;
    logic [ROT_W-1:0]   in_rotation;
    logic               rotate_flag;
    logic               out_valid;
    logic [SUM_W-1:0]   out_sum;
    modport master(output in_valid_1, in_score, in_valid_2, in_dart, in_rotation, rotate_flag,
                   input out_valid, out_sum);
    modport slave(input in_valid_1, in_score, in_valid_2, in_dart, in_rotation, rotate_flag,
                  output out_valid, out_sum);
endinterface

// File: rtl/tpcd_lfsr16.sv
// tpcd_lfsr16: 16-bit Galois LFSR with seed load (zero seed replaced by the default)
module tpcd_lfsr16
    import tpcd_pkg::*;
#(
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [7:0]  field
);
    logic [15:0] value;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) value <= DEFAULT_SEED;
        else if (load) value <= seed == 16'h0000 ? DEFAULT_SEED : seed;
        else if (step) value <= (value >> 1) ^ (value[0] ? TAPS : 16'h0000);
    end
    assign field = value[7:0];
endmodule

// File: rtl/tpcd_pattern_gen.sv
// tpcd_pattern_gen: drives score/dart bursts into the scoring core and captures its result
module tpcd_pattern_gen
    import tpcd_pkg::*;
#(
    parameter int          GAP_CYCLES = 2,
    parameter int          TIMEOUT    = 100,
    parameter logic [15:0] LFSR_TAPS  = 16'hB400
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [15:0]        seed,
    input  logic [3:0]         num_darts,
    tpcd_pattern_gen_if.master core,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [SUM_W-1:0]   result_sum
);
    localparam int CMAX = TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES;
    localparam int CW = $clog2((CMAX > NUM_SCORES ? CMAX : NUM_SCORES) + 1);
    state_t state, next;
    logic [CW-1:0] cnt, cnt_n;
    logic [4:0] darts;
    logic [7:0] field;
    logic accept, finish;
    assign accept = state == IDLE && start;
    assign finish = state == WAIT_RESP && next == IDLE;
    tpcd_lfsr16 #(.TAPS(LFSR_TAPS)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .step  (state == SCORE || state == DART),
        .seed  (seed),
        .field (field)
    );
    always_comb begin
        next = state;
        cnt_n = cnt + CW'(1);
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (start) next = SCORE;
            end
            SCORE: if (cnt == CW'(NUM_SCORES - 1)) begin
                next = GAP;
                cnt_n = '0;
            end
            GAP: if (cnt == CW'(GAP_CYCLES - 1)) begin
                next = DART;
                cnt_n = '0;
            end
            DART: if (cnt == CW'(darts) - CW'(1)) begin
                next = WAIT_RESP;
                cnt_n = '0;
            end
            // a response on the final counted cycle wins over the timeout
            WAIT_RESP: if (core.out_valid || cnt == CW'(TIMEOUT - 1)) begin
                next = IDLE;
                cnt_n = '0;
            end
            default: begin
                next = IDLE;
                cnt_n = '0;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            darts <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            timeout <= 1'b0;
            result_sum <= '0;
            core.in_valid_1 <= 1'b0;
            core.in_score <= '0;
            core.in_valid_2 <= 1'b0;
            core.in_dart <= '0;
            core.in_rotation <= '0;
            core.rotate_flag <= 1'b0;
        end else begin
            state <= next;
            cnt <= cnt_n;
            busy <= next != IDLE;
            done <= finish;
            core.in_valid_1 <= state == SCORE;
            core.in_score <= state == SCORE ? field[2:0] : '0;
            core.in_valid_2 <= state == DART;
            core.in_dart <= state == DART ? field[3:0] : '0;
            core.in_rotation <= state == DART ? field[6:4] : '0;
            core.rotate_flag <= state == DART && field[7];
            if (accept) begin
                darts <= dart_count(num_darts);
                timeout <= 1'b0;
                result_sum <= '0;
            end
            if (finish) begin
                timeout <= !core.out_valid;
                result_sum <= core.out_valid ? core.out_sum : '0;
            end
        end
    end
endmodule

// File: tb/tb_tpcd_pattern_gen.sv
// tb_tpcd_pattern_gen: directed checks of bursts, gap, response capture, timeout and reset abort
module tb_tpcd_pattern_gen;
    import tpcd_pkg::*;
    localparam int GAP = 2;
    localparam int TO = 100;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [15:0] seed = '0;
    logic [3:0] num_darts = '0;
    logic busy, done, timeout;
    logic [6:0] result_sum;
    tpcd_pattern_gen_if bus();
    always #5 clk = ~clk;
    tpcd_pattern_gen #(.GAP_CYCLES(GAP), .TIMEOUT(TO), .LFSR_TAPS(16'hB400)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .seed       (seed),
        .num_darts  (num_darts),
        .core       (bus.master),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .result_sum (result_sum)
    );
    int tests = 0;
    int fails = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    logic [2:0] sc_q[$];
    logic [7:0] dt_q[$];
    int first_v1, first_v2, last_v2, gap_n, done_c;
    logic got_done, early_drop, leak, busy0, busy_at_done, cap_to, done_after;
    logic [6:0] cap_sum, rs0;
    // one pattern: start, record bursts, optionally answer resp_d cycles after the last dart
    task automatic run(input logic [15:0] s, input logic [3:0] nd, input int resp_d,
                       input logic [6:0] sum, input int restart_at);
        int nd_eff;
        nd_eff = nd == 4'd0 ? 16 : int'(nd);
        sc_q.delete();
        dt_q.delete();
        first_v1 = -1; first_v2 = -1; last_v2 = -1; gap_n = 0; done_c = -1;
        got_done = 0; early_drop = 0; leak = 0; busy_at_done = 1; cap_to = 1'bx; cap_sum = 'x;
        @(negedge clk);
        start = 1; seed = s; num_darts = nd;
        for (int c = 0; c < 400 && !got_done; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            if (c == restart_at) seed = 16'h1234;
            if (c == 0) begin
                busy0 = busy;
                rs0 = result_sum;
            end
            if (bus.in_valid_1) begin
                if (first_v1 < 0) first_v1 = c;
                sc_q.push_back(bus.in_score);
            end else if (bus.in_score != 0) leak = 1;
            if (bus.in_valid_2) begin
                if (first_v2 < 0) first_v2 = c;
                last_v2 = c;
                dt_q.push_back({bus.rotate_flag, bus.in_rotation, bus.in_dart});
            end else if ({bus.rotate_flag, bus.in_rotation, bus.in_dart} != 0) leak = 1;
            if (!bus.in_valid_1 && !bus.in_valid_2 && sc_q.size() == 16 && dt_q.size() == 0) gap_n++;
            if (done) begin
                got_done = 1;
                done_c = c;
                cap_to = timeout;
                cap_sum = result_sum;
                busy_at_done = busy;
            end else if (!busy) early_drop = 1;
            bus.out_valid = resp_d >= 0 && dt_q.size() == nd_eff && c == last_v2 + resp_d;
            bus.out_sum = bus.out_valid ? sum : 7'd0;
        end
        start = 0;
        bus.out_valid = 0;
        bus.out_sum = 0;
        @(negedge clk);
        done_after = done;
        check("done_seen", 32'(got_done), 1);
    endtask
    logic [2:0] exp_sc[16] = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                               3'd0, 3'd4, 3'd2, 3'd5, 3'd6, 3'd3, 3'd5, 3'd2};
    logic [2:0] exp_ace[6] = '{3'd1, 3'd0, 3'd0, 3'd4, 3'd6, 3'd7};
    logic [7:0] exp_dt[3] = '{8'h41, 8'h20, 8'h10};
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.out_valid = 0;
        bus.out_sum = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_result", 32'(result_sum), 0);
        check("rst_valids", 32'({bus.in_valid_1, bus.in_valid_2}), 0);
        // seed 1, 3 darts, answer 45; a start during SCORE must be ignored
        run(16'h0001, 4'd3, 5, 7'd45, 5);
        check("a_busy_rise", 32'(busy0), 1);
        check("a_first_v1", 32'(first_v1), 1);
        check("a_score_cnt", 32'(sc_q.size()), 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("a_score%0d", i), i < sc_q.size() ? 32'(sc_q[i]) : 32'hDEAD, 32'(exp_sc[i]));
        check("a_gap", 32'(gap_n), GAP);
        check("a_first_v2", 32'(first_v2), 17 + GAP);
        check("a_dart_cnt", 32'(dt_q.size()), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("a_dart%0d", i), i < dt_q.size() ? 32'(dt_q[i]) : 32'hDEAD, 32'(exp_dt[i]));
        check("a_done_lat", 32'(done_c - last_v2), 6);
        check("a_sum", 32'(cap_sum), 45);
        check("a_timeout", 32'(cap_to), 0);
        check("a_busy_fall", 32'(busy_at_done), 0);
        check("a_done_pulse", 32'(done_after), 0);
        check("a_busy_hold", 32'(early_drop), 0);
        check("a_data_zero", 32'(leak), 0);
        // stray response while idle
        @(negedge clk);
        bus.out_valid = 1;
        bus.out_sum = 7'd99;
        repeat (2) @(negedge clk);
        bus.out_valid = 0;
        bus.out_sum = 0;
        @(negedge clk);
        check("idle_result", 32'(result_sum), 45);
        check("idle_done", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
        // zero seed behaves as ACE1, zero darts means 16, no response -> timeout
        run(16'h0000, 4'd0, -1, 7'd0, -1);
        check("b_result_clear", 32'(rs0), 0);
        for (int i = 0; i < 6; i++)
            check($sformatf("b_score%0d", i), i < sc_q.size() ? 32'(sc_q[i]) : 32'hDEAD, 32'(exp_ace[i]));
        check("b_dart_cnt", 32'(dt_q.size()), 16);
        check("b_done_lat", 32'(done_c - last_v2), TO);
        check("b_timeout", 32'(cap_to), 1);
        check("b_sum", 32'(cap_sum), 0);
        // response on the last counted cycle still counts
        run(16'h0001, 4'd1, TO - 1, 7'd77, -1);
        check("c_dart_cnt", 32'(dt_q.size()), 1);
        check("c_dart0", dt_q.size() > 0 ? 32'(dt_q[0]) : 32'hDEAD, 32'h41);
        check("c_done_lat", 32'(done_c - last_v2), TO);
        check("c_timeout", 32'(cap_to), 0);
        check("c_sum", 32'(cap_sum), 77);
        // asynchronous reset during the dart burst
        @(negedge clk);
        start = 1; seed = 16'h0001; num_darts = 4'd3;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 40 && !bus.in_valid_2; c++) @(negedge clk);
        check("r_in_dart_phase", 32'(bus.in_valid_2), 1);
        #2 rst_n = 0;
        #1;
        check("r_v2_async", 32'(bus.in_valid_2), 0);
        check("r_fields_async", 32'({bus.rotate_flag, bus.in_rotation, bus.in_dart}), 0);
        check("r_busy_async", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        check("r_idle_busy", 32'(busy), 0);
        check("r_idle_valids", 32'({bus.in_valid_1, bus.in_valid_2}), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
